// File: rtl/lorenz_integrator_fx_pkg.sv
// Shared types and helpers for the fixed-point Lorenz integrator.
//   state_t    : sequencer states
//   W/FRAC     : default data width and fractional bits
//   Q_ONE_DEF  : 1.0 in the default Q format
//   q_max/q_min: saturation limits for a given width
//   sat_add/sat_sub: widened add/subtract, clipped to a given width, with a saturation flag
// The helpers work on a 64-bit signed carrier, so widths up to 62 bits are supported.
package lorenz_integrator_fx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_UPD,
      ST_OUT,
      ST_DONE
   } state_t;

   localparam int W_DEF       = 32;
   localparam int FRAC_DEF    = 16;
   localparam int NSTEP_W_DEF = 16;

   localparam logic signed [W_DEF-1:0] Q_ONE_DEF = W_DEF'(1 << FRAC_DEF);

   typedef logic signed [63:0] wide_t;

   typedef struct packed {
      logic  sat;
      wide_t val;
   } sat_res_t;

   function automatic wide_t q_max(input int w);
      return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
   endfunction

   function automatic wide_t q_min(input int w);
      return -(wide_t'(1) <<< (w - 1));
   endfunction

   function automatic sat_res_t sat_clip(input wide_t v, input int w);
      sat_res_t r;
      r.sat = 1'b0;
      r.val = v;
      if (v > q_max(w)) begin
         r.sat = 1'b1;
         r.val = q_max(w);
      end else if (v < q_min(w)) begin
         r.sat = 1'b1;
         r.val = q_min(w);
      end
      return r;
   endfunction

   function automatic sat_res_t sat_add(input wide_t a, input wide_t b, input int w);
      return sat_clip(a + b, w);
   endfunction

   function automatic sat_res_t sat_sub(input wide_t a, input wide_t b, input int w);
      return sat_clip(a - b, w);
   endfunction

endpackage

// File: rtl/lorenz_integrator_fx_if.sv
// Output point stream of the Lorenz integrator (valid/ready).
//   out_valid : x/y/z/step_idx hold a new point
//   out_ready : downstream accepts the point
//   x, y, z   : current state, signed Q format
//   step_idx  : 1-based index of the point on the stream
// master = integrator side, slave = consumer side.
interface lorenz_integrator_fx_if #(
   parameter int W       = 32,
   parameter int NSTEP_W = 16
);
   logic                out_valid;
   logic                out_ready;
   logic signed [W-1:0] x;
   logic signed [W-1:0] y;
   logic signed [W-1:0] z;
   logic [NSTEP_W-1:0]  step_idx;

   modport master (
      output out_valid, x, y, z, step_idx,
      input  out_ready
   );

   modport slave (
      input  out_valid, x, y, z, step_idx,
      output out_ready
   );
endinterface

// File: rtl/lorenz_integrator_fx_mul.sv
// Combinational signed W x W fixed-point multiply.
//   a, b : signed Q operands
//   p    : full product >>> FRAC (floor), saturated to W bits
//   sat  : high when p was clipped
module lorenz_integrator_fx_mul
   import lorenz_integrator_fx_pkg::*;
#(
   parameter int W    = W_DEF,
   parameter int FRAC = FRAC_DEF
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] p,
   output logic                sat
);

   logic signed [2*W-1:0] a_ext, b_ext, prod, shf;
   logic                  sat_hi, sat_lo;

   assign a_ext = {{W{a[W-1]}}, a};
   assign b_ext = {{W{b[W-1]}}, b};
   assign prod  = a_ext * b_ext;
   assign shf   = prod >>> FRAC;

   // The result fits in W bits only when bits [2W-1:W-1] are all sign copies.
   assign sat_hi = ~shf[2*W-1] &  (|shf[2*W-2:W-1]);
   assign sat_lo =  shf[2*W-1] & ~(&shf[2*W-2:W-1]);
   assign sat    = sat_hi | sat_lo;

   always_comb begin
      p = shf[W-1:0];
      if (sat_hi) p = {1'b0, {(W-1){1'b1}}};
      if (sat_lo) p = {1'b1, {(W-1){1'b0}}};
   end

endmodule

// File: rtl/lorenz_integrator_fx.sv
// Forward-Euler fixed-point Lorenz integrator with one time-shared multiplier.
//   clk, reset_n             : clock, async active-low reset
//   start/abort/load_init    : run control
//   x0,y0,z0                 : initial state loaded on start when load_init=1
//   sigma,rho,beta,dt        : parameters, sampled on accepted start
//   num_steps                : points per run
//   busy, done, overflow     : status (done is a one-cycle pulse, overflow sticky per run)
//   pt                       : output point stream (valid/ready)
//
// state   | meaning
// IDLE    | waiting for start
// CALC    | one multiply per cycle, mcnt 0..6 (mcnt 7 = setup cycle after start)
// UPD     | commit x/y/z, advance step_idx
// OUT     | present point, wait for out_ready
// DONE    | one-cycle done pulse
module lorenz_integrator_fx
   import lorenz_integrator_fx_pkg::*;
#(
   parameter int                  W       = W_DEF,
   parameter int                  FRAC    = FRAC_DEF,
   parameter int                  NSTEP_W = NSTEP_W_DEF,
   parameter logic signed [W-1:0] INIT_X  = W'(Q_ONE_DEF),
   parameter logic signed [W-1:0] INIT_Y  = W'(Q_ONE_DEF),
   parameter logic signed [W-1:0] INIT_Z  = W'(Q_ONE_DEF)
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic                abort,
   input  logic                load_init,
   input  logic signed [W-1:0] x0,
   input  logic signed [W-1:0] y0,
   input  logic signed [W-1:0] z0,
   input  logic signed [W-1:0] sigma,
   input  logic signed [W-1:0] rho,
   input  logic signed [W-1:0] beta,
   input  logic signed [W-1:0] dt,
   input  logic [NSTEP_W-1:0]  num_steps,
   output logic                busy,
   output logic                done,
   output logic                overflow,
   lorenz_integrator_fx_if.master pt
);

   state_t              state_q, state_d;
   logic [2:0]          mcnt_q, mcnt_d;
   logic signed [W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
   logic signed [W-1:0] sigma_q, sigma_d, rho_q, rho_d, beta_q, beta_d, dt_q, dt_d;
   logic signed [W-1:0] m0_q, m0_d, m1_q, m1_d, m2_q, m2_d, m3_q, m3_d;
   logic signed [W-1:0] m4_q, m4_d, m5_q, m5_d, m6_q, m6_d;
   logic [NSTEP_W-1:0]  nsteps_q, nsteps_d, step_idx_q, step_idx_d;
   logic                overflow_q, overflow_d;

   logic signed [W-1:0] sub_a, sub_b, mul_a, mul_b, mul_p;
   logic                mul_sat;
   sat_res_t            sub_r, add_x, add_y, add_z;

   // At most one subtraction feeds the multiplier per cycle, so it is shared too.
   always_comb begin
      sub_a = '0;
      sub_b = '0;
      case (mcnt_q)
         3'd0:    begin sub_a = y_q;   sub_b = x_q;  end
         3'd1:    begin sub_a = rho_q; sub_b = z_q;  end
         3'd5:    begin sub_a = m1_q;  sub_b = y_q;  end
         3'd6:    begin sub_a = m2_q;  sub_b = m3_q; end
         default: ;
      endcase
      sub_r = sat_sub(wide_t'(sub_a), wide_t'(sub_b), W);

      mul_a = '0;
      mul_b = '0;
      case (mcnt_q)
         3'd0:    begin mul_a = sigma_q; mul_b = sub_r.val[W-1:0]; end
         3'd1:    begin mul_a = x_q;     mul_b = sub_r.val[W-1:0]; end
         3'd2:    begin mul_a = x_q;     mul_b = y_q;              end
         3'd3:    begin mul_a = beta_q;  mul_b = z_q;              end
         3'd4:    begin mul_a = m0_q;    mul_b = dt_q;             end
         3'd5:    begin mul_a = sub_r.val[W-1:0]; mul_b = dt_q;    end
         3'd6:    begin mul_a = sub_r.val[W-1:0]; mul_b = dt_q;    end
         default: ;
      endcase
   end

   lorenz_integrator_fx_mul #(.W(W), .FRAC(FRAC)) u_mul (
      .a   (mul_a),
      .b   (mul_b),
      .p   (mul_p),
      .sat (mul_sat)
   );

   assign add_x = sat_add(wide_t'(x_q), wide_t'(m4_q), W);
   assign add_y = sat_add(wide_t'(y_q), wide_t'(m5_q), W);
   assign add_z = sat_add(wide_t'(z_q), wide_t'(m6_q), W);

   always_comb begin
      state_d    = state_q;
      mcnt_d     = mcnt_q;
      x_d        = x_q;
      y_d        = y_q;
      z_d        = z_q;
      sigma_d    = sigma_q;
      rho_d      = rho_q;
      beta_d     = beta_q;
      dt_d       = dt_q;
      nsteps_d   = nsteps_q;
      step_idx_d = step_idx_q;
      overflow_d = overflow_q;
      m0_d = m0_q; m1_d = m1_q; m2_d = m2_q; m3_d = m3_q;
      m4_d = m4_q; m5_d = m5_q; m6_d = m6_q;

      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  sigma_d    = sigma;
                  rho_d      = rho;
                  beta_d     = beta;
                  dt_d       = dt;
                  nsteps_d   = num_steps;
                  step_idx_d = '0;
                  overflow_d = 1'b0;
                  // 7 wraps to 0 on the next cycle: one setup cycle before the first multiply.
                  mcnt_d     = 3'd7;
                  if (load_init) begin
                     x_d = x0;
                     y_d = y0;
                     z_d = z0;
                  end
                  state_d = (num_steps == '0) ? ST_DONE : ST_CALC;
               end
            end
            ST_CALC: begin
               mcnt_d = mcnt_q + 3'd1;
               if (mcnt_q != 3'd7) begin
                  if (mul_sat || sub_r.sat) overflow_d = 1'b1;
               end
               case (mcnt_q)
                  3'd0:    m0_d = mul_p;
                  3'd1:    m1_d = mul_p;
                  3'd2:    m2_d = mul_p;
                  3'd3:    m3_d = mul_p;
                  3'd4:    m4_d = mul_p;
                  3'd5:    m5_d = mul_p;
                  3'd6:    m6_d = mul_p;
                  default: ;
               endcase
               if (mcnt_q == 3'd6) state_d = ST_UPD;
            end
            ST_UPD: begin
               x_d        = add_x.val[W-1:0];
               y_d        = add_y.val[W-1:0];
               z_d        = add_z.val[W-1:0];
               step_idx_d = step_idx_q + NSTEP_W'(1);
               if (add_x.sat || add_y.sat || add_z.sat) overflow_d = 1'b1;
               state_d    = ST_OUT;
            end
            ST_OUT: begin
               if (pt.out_ready) begin
                  if (step_idx_q < nsteps_q) begin
                     mcnt_d  = 3'd0;
                     state_d = ST_CALC;
                  end else begin
                     state_d = ST_DONE;
                  end
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         mcnt_q     <= '0;
         x_q        <= INIT_X;
         y_q        <= INIT_Y;
         z_q        <= INIT_Z;
         sigma_q    <= '0;
         rho_q      <= '0;
         beta_q     <= '0;
         dt_q       <= '0;
         nsteps_q   <= '0;
         step_idx_q <= '0;
         overflow_q <= 1'b0;
         m0_q <= '0; m1_q <= '0; m2_q <= '0; m3_q <= '0;
         m4_q <= '0; m5_q <= '0; m6_q <= '0;
      end else begin
         state_q    <= state_d;
         mcnt_q     <= mcnt_d;
         x_q        <= x_d;
         y_q        <= y_d;
         z_q        <= z_d;
         sigma_q    <= sigma_d;
         rho_q      <= rho_d;
         beta_q     <= beta_d;
         dt_q       <= dt_d;
         nsteps_q   <= nsteps_d;
         step_idx_q <= step_idx_d;
         overflow_q <= overflow_d;
         m0_q <= m0_d; m1_q <= m1_d; m2_q <= m2_d; m3_q <= m3_d;
         m4_q <= m4_d; m5_q <= m5_d; m6_q <= m6_d;
      end
   end

   assign busy         = (state_q == ST_CALC) || (state_q == ST_UPD) || (state_q == ST_OUT);
   assign done         = (state_q == ST_DONE);
   assign overflow     = overflow_q;
   assign pt.out_valid = (state_q == ST_OUT);
   assign pt.x         = x_q;
   assign pt.y         = y_q;
   assign pt.z         = z_q;
   assign pt.step_idx  = step_idx_q;

endmodule

// File: tb/tb_lorenz_integrator_fx.sv
// Directed bench for lorenz_integrator_fx: hand-computed points plus a
// bit-accurate reference model for multi-step runs.
module tb_lorenz_integrator_fx;

   localparam int W  = 32;
   localparam int NW = 16;

   logic                clk = 1'b0;
   logic                reset_n = 1'b0;
   logic                start = 1'b0;
   logic                abort = 1'b0;
   logic                load_init = 1'b0;
   logic signed [W-1:0] x0, y0, z0, sigma, rho, beta, dt;
   logic [NW-1:0]       num_steps;
   logic                busy, done, overflow;

   lorenz_integrator_fx_if #(.W(W), .NSTEP_W(NW)) pt ();

   lorenz_integrator_fx #(.W(W), .FRAC(16), .NSTEP_W(NW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .abort     (abort),
      .load_init (load_init),
      .x0        (x0),
      .y0        (y0),
      .z0        (z0),
      .sigma     (sigma),
      .rho       (rho),
      .beta      (beta),
      .dt        (dt),
      .num_steps (num_steps),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow),
      .pt        (pt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int pt_cnt = 0;

   always @(posedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
      if (pt.out_valid && pt.out_ready) pt_cnt <= pt_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // reference model (64-bit integers, floor shift, clamp to 32 bits)
   longint mx, my, mz, ms, mr, mb, md;
   bit     movf;

   function automatic longint sat32(input longint v);
      if (v > 64'sd2147483647) begin
         movf = 1'b1;
         return 64'sd2147483647;
      end
      if (v < -64'sd2147483648) begin
         movf = 1'b1;
         return -64'sd2147483648;
      end
      return v;
   endfunction

   function automatic longint fmul(input longint a, input longint b);
      longint p;
      p = a * b;
      return sat32(p >>> 16);
   endfunction

   task automatic model_step();
      longint m0, m1, m2, m3, m4, m5, m6;
      m0 = fmul(ms, sat32(my - mx));
      m1 = fmul(mx, sat32(mr - mz));
      m2 = fmul(mx, my);
      m3 = fmul(mb, mz);
      m4 = fmul(m0, md);
      m5 = fmul(sat32(m1 - my), md);
      m6 = fmul(sat32(m2 - m3), md);
      mx = sat32(mx + m4);
      my = sat32(my + m5);
      mz = sat32(mz + m6);
   endtask

   task automatic do_start(input bit ld, input int n);
      load_init = ld;
      num_steps = NW'(n);
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ms = sigma; mr = rho; mb = beta; md = dt;
      movf = 1'b0;
      if (ld) begin
         mx = x0; my = y0; mz = z0;
      end
   endtask

   task automatic wait_valid(output int cyc, output bit ok);
      cyc = 0;
      while (!pt.out_valid && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      ok = pt.out_valid;
      if (!ok) chk("valid_timeout", 32'd0, 32'd1);
   endtask

   // Consume n points, comparing each with the model; optionally stall one point.
   task automatic collect(input int n, input int stall_pt, input bit last, input bit lat);
      for (int k = 1; k <= n; k++) begin
         int          cyc;
         bit          ok;
         bit          bad;
         logic [31:0] hx, hy, hz;
         wait_valid(cyc, ok);
         if (!ok) return;
         model_step();
         if (lat && k == 1) chk("lat_first", cyc, 32'd9);
         if (k == 2 && stall_pt != 1) chk("lat_next", cyc, 32'd8);
         chk("x", pt.x, 32'(mx));
         chk("y", pt.y, 32'(my));
         chk("z", pt.z, 32'(mz));
         chk("step_idx", 32'(pt.step_idx), k);
         if (k == stall_pt) begin
            pt.out_ready = 1'b0;
            hx = pt.x; hy = pt.y; hz = pt.z;
            bad = 1'b0;
            repeat (20) begin
               @(posedge clk); #1;
               if (!pt.out_valid || pt.x !== hx || pt.y !== hy || pt.z !== hz ||
                   32'(pt.step_idx) !== k) bad = 1'b1;
            end
            chk("stall_hold", 32'(bad), 32'd0);
            pt.out_ready = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (last) begin
         chk("done_after_last", 32'(done), 32'd1);
         chk("busy_in_done", 32'(busy), 32'd0);
         chk("overflow", 32'(overflow), 32'(movf));
      end
   endtask

   task automatic set_defaults();
      sigma = 32'sh000A_0000;
      rho   = 32'sh001C_0000;
      beta  = 32'sh0002_AAAA;
      dt    = 32'sh0000_028F;
      x0    = 32'sh0001_0000;
      y0    = 32'sh0001_0000;
      z0    = 32'sh0001_0000;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, p0;
      set_defaults();
      num_steps    = '0;
      pt.out_ready = 1'b1;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_x", pt.x, 32'h0001_0000);
      chk("rst_y", pt.y, 32'h0001_0000);
      chk("rst_z", pt.z, 32'h0001_0000);
      chk("rst_valid", 32'(pt.out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ovf", 32'(overflow), 32'd0);
      chk("rst_idx", 32'(pt.step_idx), 32'd0);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;

      // 1: single step from (1,1,1)
      do_start(1'b1, 1);
      chk("t1_busy", 32'(busy), 32'd1);
      collect(1, 0, 1'b1, 1'b1);
      chk("t1_x", pt.x, 32'h0001_0000);
      chk("t1_y", pt.y, 32'h0001_4286);
      chk("t1_z", pt.z, 32'h0000_FBBC);
      @(posedge clk); #1;
      chk("t1_done_off", 32'(done), 32'd0);

      // 2: three steps, point 2 stalled, inputs disturbed mid-run
      d0 = done_cnt;
      do_start(1'b1, 3);
      sigma = '0; rho = '0; dt = 32'sh0001_0000; num_steps = 16'd1;
      collect(3, 2, 1'b1, 1'b1);
      set_defaults();
      repeat (3) @(posedge clk);
      #1;
      chk("t2_single_done", done_cnt - d0, 32'd1);

      // 3: saturation everywhere (beta=0, dt=1.0)
      x0 = 32'sh7FFF_0000; y0 = 32'sh7FFF_0000; z0 = 32'sh7FFF_0000;
      beta = '0; dt = 32'sh0001_0000;
      do_start(1'b1, 1);
      collect(1, 0, 1'b1, 1'b1);
      chk("t3_x", pt.x, 32'h7FFF_0000);
      chk("t3_y", pt.y, 32'hFFFF_0000);
      chk("t3_z", pt.z, 32'h7FFF_FFFF);
      chk("t3_ovf", 32'(overflow), 32'd1);
      set_defaults();
      @(posedge clk); #1;

      // 4: abort in CALC of step 2, then continue without reload
      d0 = done_cnt;
      do_start(1'b1, 3);
      chk("t4_ovf_clear", 32'(overflow), 32'd0);
      collect(1, 0, 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      chk("t4_busy", 32'(busy), 32'd0);
      chk("t4_valid", 32'(pt.out_valid), 32'd0);
      chk("t4_x", pt.x, 32'h0001_0000);
      chk("t4_y", pt.y, 32'h0001_4286);
      chk("t4_z", pt.z, 32'h0000_FBBC);
      repeat (3) @(posedge clk);
      #1;
      chk("t4_no_done", done_cnt - d0, 32'd0);
      x0 = 32'sh0123_0000;
      do_start(1'b0, 1);
      collect(1, 0, 1'b1, 1'b1);
      set_defaults();
      @(posedge clk); #1;

      // 5: zero-length run, then start while busy
      d0 = done_cnt;
      p0 = pt_cnt;
      do_start(1'b1, 0);
      chk("t5_done", 32'(done), 32'd1);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_valid", 32'(pt.out_valid), 32'd0);
      @(posedge clk); #1;
      chk("t5_done_off", 32'(done), 32'd0);
      do_start(1'b1, 2);
      repeat (3) @(posedge clk);
      #1;
      x0 = 32'sh0005_0000; num_steps = 16'd5; load_init = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      set_defaults();
      collect(2, 0, 1'b1, 1'b0);
      repeat (12) @(posedge clk);
      #1;
      chk("t5_points", pt_cnt - p0, 32'd2);
      chk("t5_dones", done_cnt - d0, 32'd2);

      // 6: reset while a point is waiting in OUT
      pt.out_ready = 1'b0;
      do_start(1'b1, 2);
      begin
         int cyc;
         bit ok;
         wait_valid(cyc, ok);
      end
      reset_n = 1'b0;
      #1;
      chk("t6_x", pt.x, 32'h0001_0000);
      chk("t6_y", pt.y, 32'h0001_0000);
      chk("t6_z", pt.z, 32'h0001_0000);
      chk("t6_valid", 32'(pt.out_valid), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      pt.out_ready = 1'b1;
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;

      // long run against the model
      do_start(1'b1, 1000);
      collect(1000, 0, 1'b1, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
